freq_bcd_counter: RTL and testbench
===================================

// Module: freq_bcd_counter
// PURPOSE
// - Upstream stage of the BCD->7-segment decoder in the TTL frequency tester.
// - Counts rising edges of an asynchronous TTL input over a fixed gate window.
// - At each gate end, latches the count as NUM_DIGITS BCD digits.
// - Time-multiplexes the latched digits onto one 4-bit code bus that feeds the
//   decoder's S input, and drives an active-low digit-select.
// - Code 4'b1010 (decoder shows "-") is the overflow/no-result indication.
// PARAMETERS
// - NUM_DIGITS   4        BCD digits counted and displayed (range 2..8)
// - GATE_CYCLES  50000000 clk cycles per gate window (1 s at 50 MHz)
// - SCAN_CYCLES  50000    clk cycles each digit is shown (1 ms at 50 MHz)
// PORTS
// - clk        in   1             system clock, rising edge
// - rst        in   1             synchronous reset, active-high
// - sig_in     in   1             asynchronous TTL input under test
// - bcd_digit  out  4             digit code to decoder S: 0..9, or 4'b1010
// - digit_sel  out  NUM_DIGITS    active-low one-hot enable; bit 0 = least-significant digit
// - bcd_all    out  4*NUM_DIGITS  latched result; digit 0 in [3:0]
// - freq_valid out  1             high once the first gate window has completed
// - overflow   out  1             latched result overflowed (all digits = 4'b1010)
// BEHAVIOUR
// - Reset (rst=1 at a clk edge) sets:
//   - all counters, the synchronizer and the edge detector to 0;
//   - bcd_all = all 4'b1010, freq_valid = 0, overflow = 0;
//   - scan index = 0, so digit_sel = ~1 and bcd_digit = 4'b1010.
// - Reset mid-window discards the partial count. The next window starts on the
//   first cycle after rst deasserts.
// - Input path: 2-FF synchronizer, then a rising-edge detector (sync & ~sync_d).
//   - A sig_in rising edge increments the count 3 clk cycles later.
//   - sig_in pulses shorter than 1 clk period may be missed; this is accepted.
// - Count chain: NUM_DIGITS cascaded decade counters.
//   - Digit k rolls 9->0 and carries into digit k+1 in the same cycle.
//   - Carry is combinational, so an all-9s value becomes all-0s in one cycle.
// - Overflow: an increment while all digits are 9 sets the sticky ovf_run flag.
//   - Digits freeze at all-9s for the rest of the window.
// - Gate timer counts 0..GATE_CYCLES-1 and wraps. gate_end = timer at terminal count.
// - On a gate_end cycle:
//   - bcd_all <= ovf_run ? all 4'b1010 : count;
//   - overflow <= ovf_run; freq_valid <= 1;
//   - count and ovf_run clear.
// - An edge pulse coinciding with gate_end counts into the new window (count = 1).
//   It is not lost and not counted twice.
// - Result update latency: bcd_all changes on the clk edge ending the gate_end cycle.
//   The result is then held constant for the entire next window.
// - Scan:
//   - scan timer counts 0..SCAN_CYCLES-1; its terminal count advances the scan index.
//   - Index runs 0..NUM_DIGITS-1 and wraps to 0.
//   - Outputs are registered: digit_sel = ~(1<<idx), bcd_digit = bcd_all[4*idx+:4].
//   - Both update in the same cycle, so there is never a glitch between code and enable.
// - Scan runs independently of the gate. A bcd_all update is visible on the next scan
//   refresh of each digit.
// - bcd_digit only ever takes the values 0..9 or 4'b1010.
// STRUCTURE
// - Shared package freq_pkg holds:
//   - localparam BCD_DASH = 4'b1010;
//   - a function giving the counter width clog2(N) for the gate and scan timers.
// - One sub-module: bcd_decade_counter
//   - ports (clk, rst, clr, inc_in, hold, digit[3:0], carry_out);
//   - instantiated NUM_DIGITS times in a generate loop;
//   - hold freezes the digit on overflow.
// - Top level holds the synchronizer, gate timer, result latch and scan mux.
// TESTING (NUM_DIGITS=4, GATE_CYCLES=1000, SCAN_CYCLES=4)
// - Reset, no input:
//   - bcd_all=16'hAAAA, freq_valid=0, digit_sel=4'b1110, bcd_digit=4'hA;
//   - after the first gate: bcd_all=16'h0000, freq_valid=1.
// - Pulse every 8 clk -> bcd_all=16'h0125 (125 edges/1000 cycles) each window, overflow=0.
// - Scan check with bcd_all=16'h0125:
//   - bcd_digit sequence is 5,2,1,0 with digit_sel 1110,1101,1011,0111;
//   - each step is held 4 cycles, then wraps.
// - Carry chain: preload a window with 1099 edges, drive clk-divided input
//   -> result 16'h1099; one more edge -> 16'h1100.
// - Overflow: NUM_DIGITS=2, 150 edges in a window -> bcd_all=8'hAA, overflow=1.
//   The next window with 42 edges -> 8'h42, overflow=0.
// - Boundaries:
//   - an edge pulse on the gate_end cycle appears in the following window's count;
//   - rst asserted mid-window returns all outputs to their reset values next cycle.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared constants and helpers for the TTL frequency counter front end.
package freq_pkg;

   localparam logic [3:0] BCD_DASH = 4'b1010;
   localparam logic [3:0] BCD_NINE = 4'd9;

   // Width of a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bcd_decade_counter.sv
// One decade of the BCD count chain: 0..9 with a combinational carry into the
// next decade, a window clear and an overflow hold.
module bcd_decade_counter
   import freq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc_in,
   input  logic       hold,
   output logic [3:0] digit,
   output logic       carry_out
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;
   logic       at_nine_s;

   assign at_nine_s = (digit_q == BCD_NINE);

   // On clr the pending increment seeds the new window instead of being lost.
   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = inc_in ? 4'd1 : 4'd0;
      end else if (inc_in && !hold) begin
         digit_d = at_nine_s ? 4'd0 : digit_q + 4'd1;
      end else begin
         digit_d = digit_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   // Carry ignores hold so the top decade's carry doubles as the overflow strobe.
   assign carry_out = inc_in & at_nine_s & ~clr;

endmodule

// File: rtl/freq_bcd_counter.sv
// Gated BCD frequency counter: counts sig_in rising edges per gate window,
// latches the result and scans the digits onto a single decoder code bus.
module freq_bcd_counter
   import freq_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int GATE_CYCLES = 50000000,
   parameter int SCAN_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sig_in,
   output logic [3:0]              bcd_digit,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] bcd_all,
   output logic                    freq_valid,
   output logic                    overflow
);

   localparam int GW = cnt_width(GATE_CYCLES);
   localparam int SW = cnt_width(SCAN_CYCLES);
   localparam int IW = cnt_width(NUM_DIGITS);
   localparam int BW = 4 * NUM_DIGITS;
   localparam logic [GW-1:0]         GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0]         SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0]         DASH_ALL  = {NUM_DIGITS{BCD_DASH}};
   localparam logic [NUM_DIGITS-1:0] SEL_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   logic                  sync1_q, sync2_q, sync_d_q;
   logic                  edge_s;
   logic [GW-1:0]         gate_q, gate_d;
   logic                  gate_end_s;
   logic [BW-1:0]         count_s;
   logic [NUM_DIGITS:0]   carry_s;
   logic                  hold_s;
   logic                  ovf_run_q, ovf_run_d;
   logic [BW-1:0]         bcd_all_q, bcd_all_d;
   logic                  overflow_q, overflow_d;
   logic                  valid_q, valid_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [3:0]            code_q, code_d;

   assign edge_s     = sync2_q & ~sync_d_q;
   assign gate_end_s = (gate_q == GATE_LAST);
   assign carry_s[0] = edge_s;
   assign hold_s     = ovf_run_q | carry_s[NUM_DIGITS];

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_decade_counter u_digit (
         .clk       (clk),
         .rst       (rst),
         .clr       (gate_end_s),
         .inc_in    (carry_s[k]),
         .hold      (hold_s),
         .digit     (count_s[4*k +: 4]),
         .carry_out (carry_s[k+1])
      );
   end

   always_comb begin
      gate_d     = gate_end_s ? '0 : gate_q + GW'(1);
      ovf_run_d  = ovf_run_q;
      bcd_all_d  = bcd_all_q;
      overflow_d = overflow_q;
      valid_d    = valid_q;
      if (gate_end_s) begin
         ovf_run_d  = 1'b0;
         bcd_all_d  = ovf_run_q ? DASH_ALL : count_s;
         overflow_d = ovf_run_q;
         valid_d    = 1'b1;
      end else if (carry_s[NUM_DIGITS]) begin
         ovf_run_d  = 1'b1;
      end else begin
         ovf_run_d  = ovf_run_q;
      end
   end

   // Code and enable are registered from the same index so they switch together.
   always_comb begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_LAST) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
         idx_d = idx_q;
      end
      sel_d  = ~(SEL_ONE << idx_q);
      code_d = bcd_all_q[{idx_q, 2'b00} +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync_d_q   <= 1'b0;
         gate_q     <= '0;
         ovf_run_q  <= 1'b0;
         bcd_all_q  <= DASH_ALL;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         scan_q     <= '0;
         idx_q      <= '0;
         sel_q      <= ~SEL_ONE;
         code_q     <= BCD_DASH;
      end else begin
         sync1_q    <= sig_in;
         sync2_q    <= sync1_q;
         sync_d_q   <= sync2_q;
         gate_q     <= gate_d;
         ovf_run_q  <= ovf_run_d;
         bcd_all_q  <= bcd_all_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         sel_q      <= sel_d;
         code_q     <= code_d;
      end
   end

   assign bcd_digit  = code_q;
   assign digit_sel  = sel_q;
   assign bcd_all    = bcd_all_q;
   assign freq_valid = valid_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_bcd_counter.sv
// Directed bench for freq_bcd_counter: reset state, gated counts, scan order,
// carry chain, overflow, gate-end edge and mid-window reset.
module tb_freq_bcd_counter;

   logic clk = 1'b0;
   logic rst;
   logic sig4, sig2, sigc;

   logic [3:0]  code4, code2, codec;
   logic [3:0]  sel4, selc;
   logic [1:0]  sel2;
   logic [15:0] all4, allc;
   logic [7:0]  all2;
   logic        valid4, valid2, validc;
   logic        ovf4, ovf2, ovfc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   freq_bcd_counter #(.NUM_DIGITS(4), .GATE_CYCLES(1000), .SCAN_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .sig_in(sig4), .bcd_digit(code4), .digit_sel(sel4),
      .bcd_all(all4), .freq_valid(valid4), .overflow(ovf4));

   freq_bcd_counter #(.NUM_DIGITS(2), .GATE_CYCLES(1000), .SCAN_CYCLES(4)) dut2 (
      .clk(clk), .rst(rst), .sig_in(sig2), .bcd_digit(code2), .digit_sel(sel2),
      .bcd_all(all2), .freq_valid(valid2), .overflow(ovf2));

   freq_bcd_counter #(.NUM_DIGITS(4), .GATE_CYCLES(2400), .SCAN_CYCLES(4)) dutc (
      .clk(clk), .rst(rst), .sig_in(sigc), .bcd_digit(codec), .digit_sel(selc),
      .bcd_all(allc), .freq_valid(validc), .overflow(ovfc));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] res;
      logic [3:0]  exp_sel;
      int          idx;

      res  = 16'h0125;
      rst  = 1'b1;
      sig4 = 1'b0;
      sig2 = 1'b0;
      sigc = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Phase A: dut4 windows of 1000 cycles; c is the cycle index since reset.
      for (int c = 0; c < 5300; c++) begin
         if (c == 0) begin
            check("rst_all4",   all4,   16'hAAAA);
            check("rst_valid4", valid4, 1'b0);
            check("rst_ovf4",   ovf4,   1'b0);
            check("rst_sel4",   sel4,   4'b1110);
            check("rst_code4",  code4,  4'hA);
            check("rst_all2",   all2,   8'hAA);
            check("rst_sel2",   sel2,   2'b10);
         end
         if (c == 999) begin
            check("valid_before_gate", valid4, 1'b0);
            check("all_before_gate",   all4,   16'hAAAA);
         end
         if (c == 1000) begin
            check("idle_all4",   all4,   16'h0000);
            check("idle_valid4", valid4, 1'b1);
         end
         if (c == 2000 || c == 3000) begin
            check("p8_all4", all4, 16'h0125);
            check("p8_ovf4", ovf4, 1'b0);
         end
         if (c >= 2004 && c < 2020) begin
            idx     = ((c - 1) / 4) % 4;
            exp_sel = ~(4'b0001 << idx);
            check("scan_code4", code4, res[4*idx +: 4]);
            check("scan_sel4",  sel4,  exp_sel);
         end
         if (c == 4000) check("gate_end_edge_old", all4, 16'h0000);
         if (c == 5000) check("gate_end_edge_new", all4, 16'h0001);
         if (c == 5299) check("hold_before_rst", all4, 16'h0001);

         if (c >= 1000 && c < 3000)      sig4 = ((c - 1000) % 8) < 4;
         else if (c >= 3997 && c < 4002) sig4 = 1'b1;
         else if (c >= 5000)             sig4 = ((c - 5000) % 8) < 4;
         else                            sig4 = 1'b0;
         @(negedge clk);
      end

      // Mid-window reset with a partial count pending in dut4.
      rst  = 1'b1;
      sig4 = 1'b0;
      @(negedge clk);
      rst  = 1'b0;

      // Phase B: overflow on dut2, carry chain on dutc, discarded count on dut4.
      for (int c = 0; c <= 4800; c++) begin
         if (c == 0) begin
            check("mrst_all4",   all4,   16'hAAAA);
            check("mrst_valid4", valid4, 1'b0);
            check("mrst_ovf4",   ovf4,   1'b0);
            check("mrst_sel4",   sel4,   4'b1110);
            check("mrst_code4",  code4,  4'hA);
            check("mrst_valid2", valid2, 1'b0);
            check("mrst_ovf2",   ovf2,   1'b0);
            check("mrst_code2",  code2,  4'hA);
            check("mrst_allc",   allc,   16'hAAAA);
            check("mrst_validc", validc, 1'b0);
            check("mrst_selc",   selc,   4'b1110);
            check("mrst_codec",  codec,  4'hA);
         end
         if (c == 1000) begin
            check("discard_all4",   all4,   16'h0000);
            check("discard_valid4", valid4, 1'b1);
            check("ovf_all2",       all2,   8'hAA);
            check("ovf_flag2",      ovf2,   1'b1);
            check("ovf_valid2",     valid2, 1'b1);
         end
         if (c == 1010) check("ovf_code2", code2, 4'hA);
         if (c == 2000) begin
            check("post_ovf_all2",  all2, 8'h42);
            check("post_ovf_flag2", ovf2, 1'b0);
         end
         if (c == 2400) begin
            check("carry_1099",  allc,   16'h1099);
            check("carry_valid", validc, 1'b1);
         end
         if (c == 4800) begin
            check("carry_1100", allc, 16'h1100);
            check("carry_ovf",  ovfc, 1'b0);
         end

         sig2 = (c < 600 || (c >= 1000 && c < 1168)) ? ((c % 4) < 2) : 1'b0;
         sigc = (c < 2198 || (c >= 2400 && c < 4600)) ? ((c % 2) == 0) : 1'b0;
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
